key_debounce4: RTL and testbench

//  Input-conditioning stage for the four-input combinational logic stage that

---
 rtl/key_debounce4_pkg.sv | 15 +
 rtl/key_debounce4_ch.sv | 103 ++++++++++
 rtl/key_debounce4.sv | 50 +++++
 tb/tb_key_debounce4.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce4_pkg.sv
// rtl/key_debounce4_pkg.sv - shared state encodings and default timing for the key debouncer
package key_debounce4_pkg;

  typedef enum logic [1:0] {
    ST_LOW  = 2'd0,
    ST_L2H  = 2'd1,
    ST_HIGH = 2'd2,
    ST_H2L  = 2'd3
  } db_state_e;

  // 20 ms at 50 MHz
  localparam int DEBOUNCE_CYC_DEF = 1000000;
  localparam int CNT_W_DEF        = 20;

endpackage

// File: rtl/key_debounce4_ch.sv
// rtl/key_debounce4_ch.sv - one channel: two-flop synchroniser plus counter debounce FSM
module key_debounce4_ch
  import key_debounce4_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic stable,
  output logic rise,
  output logic fall,
  output logic evt_nxt
);

  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYC - 1);

  logic            sync1_q, sync2_q;
  db_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            stable_q, stable_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      state_q  <= ST_LOW;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync1_q  <= key_raw;
      sync2_q  <= sync1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    unique case (state_q)
      ST_LOW: begin
        stable_d = 1'b0;
        if (sync2_q) begin
          state_d = ST_L2H;
          cnt_d   = '0;
        end
      end
      ST_L2H: begin
        if (!sync2_q) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TERM) begin
          state_d  = ST_HIGH;
          stable_d = 1'b1;
          rise_d   = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HIGH: begin
        stable_d = 1'b1;
        if (!sync2_q) begin
          state_d = ST_H2L;
          cnt_d   = '0;
        end
      end
      ST_H2L: begin
        if (sync2_q) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TERM) begin
          state_d  = ST_LOW;
          stable_d = 1'b0;
          fall_d   = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_LOW;
    endcase
  end

  assign stable  = stable_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  // exposed so the top can register key_chg in the same cycle as rise/fall
  assign evt_nxt = rise_d | fall_d;

endmodule

// File: rtl/key_debounce4.sv
// rtl/key_debounce4.sv - four-channel key debouncer feeding the a/b/c/d logic stage
module key_debounce4
  import key_debounce4_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_in,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic [3:0] key_rise,
  output logic [3:0] key_fall,
  output logic       key_chg
);

  logic [3:0] stable;
  logic [3:0] evt_nxt;
  logic       key_chg_q;

  for (genvar i = 0; i < 4; i++) begin : g_ch
    key_debounce4_ch #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .CNT_W       (CNT_W)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .key_raw(key_in[i]),
      .stable (stable[i]),
      .rise   (key_rise[i]),
      .fall   (key_fall[i]),
      .evt_nxt(evt_nxt[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) key_chg_q <= 1'b0;
    else        key_chg_q <= |evt_nxt;
  end

  assign a       = stable[0];
  assign b       = stable[1];
  assign c       = stable[2];
  assign d       = stable[3];
  assign key_chg = key_chg_q;

endmodule

// File: tb/tb_key_debounce4.sv
// tb/tb_key_debounce4.sv - directed self-checking bench for key_debounce4 (N=4)
module tb_key_debounce4;

  logic       clk;
  logic       rst_n;
  logic [3:0] key_in;
  logic       a, b, c, d;
  logic [3:0] key_rise, key_fall;
  logic       key_chg;
  logic       y;

  int checks = 0;
  int errors = 0;

  key_debounce4 #(.DEBOUNCE_CYC(4), .CNT_W(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_in  (key_in),
    .a       (a),
    .b       (b),
    .c       (c),
    .d       (d),
    .key_rise(key_rise),
    .key_fall(key_fall),
    .key_chg (key_chg)
  );

  assign y = (a & b) | (c ^ d);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n  = 1'b0;
    key_in = 4'b1111;
    step(3);
    checks++;
    if ({d, c, b, a, key_rise, key_fall, key_chg} !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0", {d, c, b, a, key_rise, key_fall, key_chg});
    end
    rst_n = 1'b1;
    step(6);
    checks++;
    if ({d, c, b, a} !== 4'b0000 || key_rise !== 4'h0) begin
      errors++;
      $display("FAIL release_edge5 got abcd=%b rise=%b want 0000/0000", {d, c, b, a}, key_rise);
    end
    step(1);
    checks++;
    if ({d, c, b, a} !== 4'b1111 || key_rise !== 4'hF || key_chg !== 1'b1) begin
      errors++;
      $display("FAIL release_edge6 got abcd=%b rise=%b chg=%b want 1111/1111/1",
               {d, c, b, a}, key_rise, key_chg);
    end
    step(1);
    checks++;
    if ({d, c, b, a} !== 4'b1111 || key_rise !== 4'h0 || key_chg !== 1'b0) begin
      errors++;
      $display("FAIL release_edge7 got abcd=%b rise=%b chg=%b want 1111/0000/0",
               {d, c, b, a}, key_rise, key_chg);
    end
  endtask

  task automatic test_bounce;
    key_in = 4'b0000;
    step(12);
    checks++;
    if ({d, c, b, a} !== 4'b0000) begin
      errors++;
      $display("FAIL settle_low got %b want 0000", {d, c, b, a});
    end
    key_in[0] = 1'b1;
    step(3);
    key_in[0] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      checks++;
      if (a !== 1'b0 || key_rise[0] !== 1'b0) begin
        errors++;
        $display("FAIL bounce_reject cyc%0d got a=%b rise0=%b want 0/0", i, a, key_rise[0]);
      end
    end
  endtask

  task automatic test_glitch;
    key_in[0] = 1'b1;
    step(10);
    checks++;
    if (a !== 1'b1) begin
      errors++;
      $display("FAIL glitch_setup got a=%b want 1", a);
    end
    key_in[0] = 1'b0;
    step(2);
    key_in[0] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1);
      checks++;
      if (a !== 1'b1 || key_fall[0] !== 1'b0) begin
        errors++;
        $display("FAIL glitch_reject cyc%0d got a=%b fall0=%b want 1/0", i, a, key_fall[0]);
      end
    end
  endtask

  task automatic test_simultaneous;
    key_in = 4'b0101;
    step(10);
    checks++;
    if ({d, c, b, a} !== 4'b0101) begin
      errors++;
      $display("FAIL simul_setup got %b want 0101", {d, c, b, a});
    end
    key_in = 4'b0011;
    step(6);
    checks++;
    if ({d, c, b, a} !== 4'b0101 || key_chg !== 1'b0) begin
      errors++;
      $display("FAIL simul_edge5 got abcd=%b chg=%b want 0101/0", {d, c, b, a}, key_chg);
    end
    step(1);
    checks++;
    if ({d, c, b, a} !== 4'b0011 || key_rise !== 4'b0010 || key_fall !== 4'b0100 || key_chg !== 1'b1) begin
      errors++;
      $display("FAIL simul_edge6 got abcd=%b rise=%b fall=%b chg=%b want 0011/0010/0100/1",
               {d, c, b, a}, key_rise, key_fall, key_chg);
    end
    step(1);
    checks++;
    if (key_rise !== 4'h0 || key_fall !== 4'h0 || key_chg !== 1'b0) begin
      errors++;
      $display("FAIL simul_edge7 got rise=%b fall=%b chg=%b want 0000/0000/0", key_rise, key_fall, key_chg);
    end
  endtask

  task automatic test_reset_midcount;
    key_in = 4'b1011;
    step(5);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({d, c, b, a} !== 4'b0000 || key_rise !== 4'h0 || key_chg !== 1'b0) begin
      errors++;
      $display("FAIL midcount_reset got abcd=%b rise=%b chg=%b want 0000/0000/0",
               {d, c, b, a}, key_rise, key_chg);
    end
    step(2);
    rst_n = 1'b1;
    step(6);
    checks++;
    if (d !== 1'b0 || key_rise !== 4'h0) begin
      errors++;
      $display("FAIL midcount_edge5 got d=%b rise=%b want 0/0000", d, key_rise);
    end
    step(1);
    checks++;
    if ({d, c, b, a} !== 4'b1011 || key_rise !== 4'b1011 || key_chg !== 1'b1) begin
      errors++;
      $display("FAIL midcount_edge6 got abcd=%b rise=%b chg=%b want 1011/1011/1",
               {d, c, b, a}, key_rise, key_chg);
    end
  endtask

  task automatic test_downstream;
    key_in = 4'b0011;
    step(10);
    checks++;
    if ({d, c, b, a} !== 4'b0011 || y !== 1'b1) begin
      errors++;
      $display("FAIL downstream_0011 got abcd=%b y=%b want 0011/1", {d, c, b, a}, y);
    end
    key_in = 4'b1100;
    step(6);
    checks++;
    if (y !== 1'b1) begin
      errors++;
      $display("FAIL downstream_hold got y=%b want 1", y);
    end
    step(1);
    checks++;
    if ({d, c, b, a} !== 4'b1100 || y !== 1'b0) begin
      errors++;
      $display("FAIL downstream_1100 got abcd=%b y=%b want 1100/0", {d, c, b, a}, y);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    key_in = 4'b0000;
    test_reset;
    test_bounce;
    test_glitch;
    test_simultaneous;
    test_reset_midcount;
    test_downstream;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
